// File: rtl/conv_8_4_pkg.sv
// Shared sizes, FSM states and signed data types for the conv_8_4 correlation engine.
package conv_8_4_pkg;

    localparam int X_LEN = 8;
    localparam int F_LEN = 4;
    localparam int Y_LEN = 5;
    localparam int IN_W  = 8;
    localparam int OUT_W = 18;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        OUTPUT  = 2'd2
    } state_e;

    typedef logic signed [IN_W-1:0]  sample_t;
    typedef logic signed [OUT_W-1:0] result_t;

endpackage

// File: rtl/conv_8_4_dot4.sv
// Combinational 4-element signed dot product: 8x8 products, 18-bit sum.
module conv_8_4_dot4
    import conv_8_4_pkg::*;
(
    input  sample_t x [F_LEN],
    input  sample_t f [F_LEN],
    output result_t y
);

    logic signed [2*IN_W-1:0] prod;
    result_t                  acc;

    always_comb begin
        prod = '0;
        acc  = '0;
        for (int j = 0; j < F_LEN; j++) begin
            prod = 16'(x[j]) * 16'(f[j]);
            acc  = acc + result_t'(prod);
        end
    end

    assign y = acc;

endmodule

// File: rtl/conv_8_4.sv
// Streaming 8-sample x 4-tap valid correlation: load x/f, emit 5 results over valid/ready.
module conv_8_4
    import conv_8_4_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [IN_W-1:0]  s_data_in_x,
    input  logic                    s_valid_x,
    output logic                    s_ready_x,
    input  logic signed [IN_W-1:0]  s_data_in_f,
    input  logic                    s_valid_f,
    output logic                    s_ready_f,
    output logic signed [OUT_W-1:0] m_data_out_y,
    output logic                    m_valid_y,
    input  logic                    m_ready_y
);

    state_e      state;
    sample_t     xmem [X_LEN];
    sample_t     fmem [F_LEN];
    logic [3:0]  x_cnt;
    logic [2:0]  f_cnt;
    logic [2:0]  m;
    logic        x_fire;
    logic        f_fire;
    sample_t     win_x [F_LEN];
    result_t     dot_y;

    assign s_ready_x = (state == LOAD) && (x_cnt < 4'(X_LEN));
    assign s_ready_f = (state == LOAD) && (f_cnt < 3'(F_LEN));
    assign x_fire    = s_valid_x && s_ready_x;
    assign f_fire    = s_valid_f && s_ready_f;

    // Sliding window of x aligned to the current output index.
    always_comb begin
        for (int j = 0; j < F_LEN; j++) begin
            win_x[j] = xmem[3'(m + 3'(j))];
        end
    end

    conv_8_4_dot4 u_dot4 (
        .x (win_x),
        .f (fmem),
        .y (dot_y)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= LOAD;
            x_cnt        <= '0;
            f_cnt        <= '0;
            m            <= '0;
            m_valid_y    <= 1'b0;
            m_data_out_y <= '0;
            for (int i = 0; i < X_LEN; i++) xmem[i] <= '0;
            for (int i = 0; i < F_LEN; i++) fmem[i] <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (x_fire) begin
                        xmem[x_cnt[2:0]] <= s_data_in_x;
                        x_cnt            <= x_cnt + 4'd1;
                    end
                    if (f_fire) begin
                        fmem[f_cnt[1:0]] <= s_data_in_f;
                        f_cnt            <= f_cnt + 3'd1;
                    end
                    if (x_cnt == 4'(X_LEN) && f_cnt == 3'(F_LEN)) begin
                        state <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    m_data_out_y <= dot_y;
                    m_valid_y    <= 1'b1;
                    state        <= OUTPUT;
                end
                OUTPUT: begin
                    if (m_ready_y) begin
                        m_valid_y <= 1'b0;
                        if (m == 3'(Y_LEN - 1)) begin
                            x_cnt <= '0;
                            f_cnt <= '0;
                            m     <= '0;
                            state <= LOAD;
                        end else begin
                            m     <= m + 3'd1;
                            state <= COMPUTE;
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_8_4.sv
// Scoreboard bench for conv_8_4: directed jobs, random stalls, idle, overflow and mid-job reset.
module tb_conv_8_4;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic signed [7:0]  s_data_in_x = '0;
    logic               s_valid_x = 1'b0;
    logic               s_ready_x;
    logic signed [7:0]  s_data_in_f = '0;
    logic               s_valid_f = 1'b0;
    logic               s_ready_f;
    logic signed [17:0] m_data_out_y;
    logic               m_valid_y;
    logic               m_ready_y = 1'b1;

    conv_8_4 dut (
        .clk          (clk),
        .reset        (reset),
        .s_data_in_x  (s_data_in_x),
        .s_valid_x    (s_valid_x),
        .s_ready_x    (s_ready_x),
        .s_data_in_f  (s_data_in_f),
        .s_valid_f    (s_valid_f),
        .s_ready_f    (s_ready_f),
        .m_data_out_y (m_data_out_y),
        .m_valid_y    (m_valid_y),
        .m_ready_y    (m_ready_y)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit stalls   = 1'b0;
    int exp_q [$];

    logic signed [7:0] tx [4][8];
    logic signed [7:0] tf [4][4];
    int                ty [4][5];
    logic signed [7:0] job_x [8];
    logic signed [7:0] job_f [4];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a handshake seen at the negedge completes on the next rising edge.
    bit                 prev_hold = 1'b0;
    logic signed [17:0] prev_data = '0;
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    check("hold_valid", int'(m_valid_y), 1);
                    check("hold_data", int'(m_data_out_y), int'(prev_data));
                end
                if (m_valid_y && m_ready_y) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL y_unexpected: got %0d, expected no output", m_data_out_y);
                    end else begin
                        check("y", int'(m_data_out_y), exp_q.pop_front());
                    end
                end
                prev_hold = m_valid_y && !m_ready_y;
                prev_data = m_data_out_y;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_ready_y = stalls ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic send_x(input int n);
        for (int i = 0; i < n; i++) begin
            int t;
            bit r;
            if (stalls) begin
                int k;
                k = $urandom_range(0, 3);
                repeat (k) begin
                    s_valid_x = 1'b0;
                    s_data_in_x = 'x;
                    @(posedge clk);
                    #1;
                end
            end
            s_valid_x = 1'b1;
            s_data_in_x = job_x[i];
            t = 0;
            do begin
                @(negedge clk);
                r = s_ready_x;
                @(posedge clk);
                #1;
                t++;
            end while (!r && t < 2000);
            if (!r) check("x_accept_timeout", 0, 1);
            s_valid_x = 1'b0;
            s_data_in_x = 'x;
        end
    endtask

    task automatic send_f(input int n);
        for (int i = 0; i < n; i++) begin
            int t;
            bit r;
            if (stalls) begin
                int k;
                k = $urandom_range(0, 3);
                repeat (k) begin
                    s_valid_f = 1'b0;
                    s_data_in_f = 'x;
                    @(posedge clk);
                    #1;
                end
            end
            s_valid_f = 1'b1;
            s_data_in_f = job_f[i];
            t = 0;
            do begin
                @(negedge clk);
                r = s_ready_f;
                @(posedge clk);
                #1;
                t++;
            end while (!r && t < 2000);
            if (!r) check("f_accept_timeout", 0, 1);
            s_valid_f = 1'b0;
            s_data_in_f = 'x;
        end
    endtask

    task automatic run_job(input int id, input int nx, input int nf, input bit expect_out);
        for (int i = 0; i < 8; i++) job_x[i] = tx[id][i];
        for (int i = 0; i < 4; i++) job_f[i] = tf[id][i];
        if (expect_out) begin
            for (int i = 0; i < 5; i++) exp_q.push_back(ty[id][i]);
        end
        fork
            send_x(nx);
            send_f(nf);
        join
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 5000) begin
            @(posedge clk);
            t++;
        end
        check("drain_pending", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int seen_valid;
        tx[0] = '{10, -20, 30, -40, 50, 60, 70, 80};
        tf[0] = '{10, 20, -30, 40};
        ty[0] = '{-2800, 3600, 400, 1600, 2800};
        tx[1] = '{-90, 100, -110, 120, -50, 40, 30, -20};
        tf[1] = '{-50, -60, 70, 80};
        ty[1] = '{400, 6000, -2000, 2200, 600};
        tx[2] = '{-128, -128, -128, -128, -128, -128, -128, -128};
        tf[2] = '{-128, -128, -128, -128};
        ty[2] = '{65536, 65536, 65536, 65536, 65536};
        tx[3] = '{-128, -128, -128, -128, -128, -128, -128, -128};
        tf[3] = '{127, 127, 127, 127};
        ty[3] = '{-65024, -65024, -65024, -65024, -65024};

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", int'(m_valid_y), 0);
        check("rst_data", int'(m_data_out_y), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst_ready_x", int'(s_ready_x), 1);
        check("rst_ready_f", int'(s_ready_f), 1);

        run_job(0, 8, 4, 1'b1);
        run_job(1, 8, 4, 1'b1);
        wait_drain();

        stalls = 1'b1;
        run_job(0, 8, 4, 1'b1);
        run_job(1, 8, 4, 1'b1);
        wait_drain();
        stalls = 1'b0;

        seen_valid = 0;
        repeat (100) begin
            @(negedge clk);
            if (m_valid_y) seen_valid++;
        end
        check("idle_valid_cycles", seen_valid, 0);
        check("idle_ready_x", int'(s_ready_x), 1);
        check("idle_ready_f", int'(s_ready_f), 1);
        @(posedge clk);
        #1;

        run_job(2, 8, 4, 1'b1);
        run_job(3, 8, 4, 1'b1);
        wait_drain();

        run_job(1, 5, 2, 1'b0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("midrst_valid", int'(m_valid_y), 0);
        check("midrst_data", int'(m_data_out_y), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_ready_x", int'(s_ready_x), 1);
        check("midrst_ready_f", int'(s_ready_f), 1);
        run_job(0, 8, 4, 1'b1);
        wait_drain();

        seen_valid = 0;
        repeat (20) begin
            @(negedge clk);
            if (m_valid_y) seen_valid++;
        end
        check("final_idle_valid_cycles", seen_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, %0d checks, %0d failures", n_checks, n_fail);
        $fatal(1, "timeout");
    end

endmodule
